// File: rtl/parking_pkg.sv
// Shared types and constants for the multi-lane parking entry controller.
package parking_pkg;

    typedef enum logic [1:0] {
        LaneIdle     = 2'd0,
        LaneWaitPass = 2'd1,
        LaneOpen     = 2'd2
    } lane_state_e;

    localparam logic [1:0] PASS_PEND0  = 2'b00;
    localparam logic [1:0] PASS_REJECT = 2'b01;
    localparam logic [1:0] PASS_ACCEPT = 2'b10;
    localparam logic [1:0] PASS_PEND1  = 2'b11;

endpackage

// File: rtl/parking_lane_fsm.sv
// One entry lane: arrival edge detect, lane FSM with timeout timer, registered pulses.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int unsigned TMR_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arrive,
    input  logic [1:0] pass_code,
    input  logic       cleared,
    input  logic       grant,
    input  logic       full,
    output logic       request,
    output logic       commit,
    output logic       leave_open,
    output logic       in_open,
    output logic       gate_up,
    output logic       gate_down,
    output logic       reject,
    output logic       timeout,
    output logic       busy
);

    lane_state_e      state_q;
    logic [TMR_W-1:0] timer_q;
    logic             arrive_q;
    logic             expired;

    assign expired    = (timer_q == TMR_W'(TIMEOUT - 1));
    assign request    = (state_q == LaneWaitPass) && (pass_code == PASS_ACCEPT);
    assign commit     = (state_q == LaneOpen) && cleared;
    assign leave_open = (state_q == LaneOpen) && (cleared || expired);
    assign in_open    = (state_q == LaneOpen);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LaneIdle;
            timer_q   <= '0;
            arrive_q  <= 1'b0;
            gate_up   <= 1'b0;
            gate_down <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            arrive_q  <= arrive;
            gate_up   <= 1'b0;
            gate_down <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
            case (state_q)
                LaneIdle: begin
                    if (arrive && !arrive_q) begin
                        if (full) begin
                            reject <= 1'b1;
                        end else begin
                            state_q <= LaneWaitPass;
                            timer_q <= '0;
                            busy    <= 1'b1;
                        end
                    end
                end
                LaneWaitPass: begin
                    if (pass_code == PASS_ACCEPT) begin
                        if (grant) begin
                            gate_up <= 1'b1;
                            state_q <= LaneOpen;
                            timer_q <= '0;
                        end else if (!expired) begin
                            // Timer saturates while an ungranted accept is retried.
                            timer_q <= timer_q + 1'b1;
                        end
                    end else if (pass_code == PASS_REJECT) begin
                        reject  <= 1'b1;
                        state_q <= LaneIdle;
                        busy    <= 1'b0;
                    end else if (expired) begin
                        timeout <= 1'b1;
                        state_q <= LaneIdle;
                        busy    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LaneOpen: begin
                    if (cleared) begin
                        gate_down <= 1'b1;
                        state_q   <= LaneIdle;
                        busy      <= 1'b0;
                    end else if (expired) begin
                        gate_down <= 1'b1;
                        timeout   <= 1'b1;
                        state_q   <= LaneIdle;
                        busy      <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= LaneIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Multi-lane parking entry controller: per-lane FSMs, accept arbitration, occupancy tracking.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned NLANES  = 2,
    parameter int unsigned CAP     = 15,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TMR_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NLANES-1:0]   arrive,
    input  logic [2*NLANES-1:0] pass_valid,
    input  logic [NLANES-1:0]   cleared,
    input  logic                exit_sensor,
    output logic [NLANES-1:0]   gate_up,
    output logic [NLANES-1:0]   gate_down,
    output logic [NLANES-1:0]   reject,
    output logic [NLANES-1:0]   timeout,
    output logic [NLANES-1:0]   busy,
    output logic [CNT_W-1:0]    occupancy,
    output logic                full,
    output logic                empty
);

    logic [NLANES-1:0] request, commit, leave_open, in_open, grant;
    logic              exit_q, exit_fall, room, found;
    logic [CNT_W-1:0]  occ_d;
    logic              full_d, empty_d;
    int unsigned       n_open, n_commit, n_release, occ_n, res_n;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        parking_lane_fsm #(
            .TMR_W   (TMR_W),
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .arrive     (arrive[i]),
            .pass_code  (pass_valid[2*i +: 2]),
            .cleared    (cleared[i]),
            .grant      (grant[i]),
            .full       (full),
            .request    (request[i]),
            .commit     (commit[i]),
            .leave_open (leave_open[i]),
            .in_open    (in_open[i]),
            .gate_up    (gate_up[i]),
            .gate_down  (gate_down[i]),
            .reject     (reject[i]),
            .timeout    (timeout[i]),
            .busy       (busy[i])
        );
    end

    assign exit_fall = exit_q && !exit_sensor;

    always_comb begin
        n_open    = 0;
        n_commit  = 0;
        n_release = 0;
        for (int i = 0; i < int'(NLANES); i++) begin
            if (in_open[i])    n_open++;
            if (commit[i])     n_commit++;
            if (leave_open[i]) n_release++;
        end
        room  = (32'(occupancy) + n_open) < CAP;
        // Lowest-index requester wins; at most one grant per cycle.
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NLANES); i++) begin
            if (room && request[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        occ_n = 32'(occupancy) + n_commit;
        if (exit_fall && (occupancy != '0)) occ_n = occ_n - 1;
        res_n = n_open - n_release;
        if (found) res_n++;
        occ_d   = CNT_W'(occ_n);
        full_d  = (occ_n + res_n) >= CAP;
        empty_d = (occ_n == 0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exit_q    <= 1'b0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            exit_q    <= exit_sensor;
            occupancy <= occ_d;
            full      <= full_d;
            empty     <= empty_d;
        end
    end

endmodule
